prefix_addsub_pipe: RTL and testbench
=====================================

# prefix_addsub_pipe

Pipelined, parametrised parallel-prefix adder/subtractor for the optimised ALU path. Operands enter through a valid/ready handshake. The Kogge-Stone-style generate/propagate tree is cut into a configurable number of register stages, and results leave through a second valid/ready handshake carrying sum, carry-out, signed overflow and zero flags. It replaces the single-cycle combinational adder where the prefix tree limits clock frequency. It sustains one operation per cycle under back-pressure.

## Interface
- N, 5: log2 of operand width; W = 2**N bits (N in 2..6).
- PIPE, 1: register boundaries inside the prefix tree (0..N); latency = PIPE+1 cycles.
- TAGW, 4: width of the opaque tag carried alongside each operation (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in, used only when sub=0.
- sub  in  1  1: compute a - b (a + ~b + 1); cin is ignored.
- tag  in  TAGW  passed unchanged to tag_out.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result.
- s  out  W  sum/difference mod 2**W.
- cout  out  1  carry out of bit W-1. For sub, 1 means no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow.
- zero  out  1  s == 0.
- tag_out  out  TAGW  tag of the presented result.

## Operation
- Stage 0 (input): form b' = sub ? ~b : b and c0 = sub ? 1 : cin. Form p = a|b', g = a&b', x = a^b'. Insert c0 as the bit -1 generate.
- Prefix levels 1..N: each level combines with the span 2**(level-1) below. Cuts fall after levels round(k*N/(PIPE+1)) for k = 1..PIPE. Levels are spread evenly, and extra levels go to later stages.
- Final stage: s = x ^ carry-in per bit; cout = G[W-1:-1]; ovf = carry into bit W-1 XOR cout; zero = ~|s.
- Output register always present. s, cout, ovf, zero and tag_out are registered and held stable while out_valid=1 and out_ready=0.
- Each stage holds a valid bit and carries only the signals later levels need: x, partial p/g, sub-independent data and tag.
- Stage k loads when it is empty or its successor loads in the same cycle. This is bubble-collapsing. in_ready equals the stage-0 load condition.
- in_ready depends combinationally on out_ready and the valid bits. It never depends on in_valid.
- Results emerge strictly in input order. No operation is dropped or duplicated.

## Timing
- Reset (synchronous): all stage valid bits 0, out_valid=0, s=0, cout=0, ovf=0, zero=0, tag_out=0. in_ready=1 in the first cycle after reset.
- Latency: an op accepted in cycle t with no stalls gives out_valid=1 in cycle t+PIPE+1.
- Throughput: 1 op/cycle while out_ready=1.
- Full: with out_ready=0, the block absorbs PIPE+1 ops and then drops in_ready to 0. When out_ready rises, in_ready=1 in that same cycle.
- Simultaneous accept and emit when full: an input is accepted in the same cycle the output is consumed, with no bubble.
- Bubbles: with in_valid gaps, an empty stage advances even if out_ready=0. Ops compact toward the output.
- reset asserted mid-operation: all in-flight ops are discarded. out_valid=0 on the next cycle, and no stale result appears afterwards.
- Inputs are sampled only when in_valid & in_ready. Values on a, b, sub, cin and tag at other times have no effect.
- PIPE=0: a single register stage, latency 1.

## Test plan
- N=5, PIPE=1, sub=0, a=0xFFFFFFFF, b=0x00000000, cin=1 -> after 2 cycles s=0x00000000, cout=1, ovf=0, zero=1.
- sub=0, a=0x7FFFFFFF, b=0x00000001, cin=0 -> s=0x80000000, cout=0, ovf=1, zero=0. Then sub=1, a=0x00000005, b=0x00000007, cin=1 (ignored) -> s=0xFFFFFFFE, cout=0, ovf=0.
- Back-to-back 64 random ops with out_ready=1 and tags 0..15 cycling -> one result per cycle, in order, matching a + (sub ? -b : b + cin) mod 2**32. Repeat with PIPE=0, 2 and 5.
- PIPE=2, out_ready=0, in_valid=1 continuously -> exactly 3 ops accepted and in_ready=0. Raise out_ready -> in_ready=1 the same cycle, and results emerge in order with no loss.
- Random in_valid/out_ready toggling (50%) over 1000 ops -> scoreboard match, and outputs stable while stalled.
- Assert reset for 1 cycle with 2 ops in flight -> out_valid=0 next cycle, all outputs 0, and no stale result later. Ops sent after reset are correct.

Source files
------------

// File: rtl/prefix_addsub_pipe.sv
// prefix_addsub_pipe: Kogge-Stone adder/subtractor, prefix tree split into PIPE+1 register stages
// with bubble-collapsing valid/ready flow control and registered sum/flag outputs.
module prefix_addsub_pipe #(
    parameter int N    = 5,
    parameter int PIPE = 1,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [(1<<N)-1:0] a,
    input  logic [(1<<N)-1:0] b,
    input  logic              cin,
    input  logic              sub,
    input  logic [TAGW-1:0]   tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [(1<<N)-1:0] s,
    output logic              cout,
    output logic              ovf,
    output logic              zero,
    output logic [TAGW-1:0]   tag_out
);
    localparam int W = 1 << N;

    // last prefix level completed by stages before k (rounded, ties toward later stages)
    function automatic int cut(input int k);
        return (2 * k * N + PIPE) / (2 * (PIPE + 1));
    endfunction

    function automatic logic [W-1:0] pfx_g(input logic [W-1:0] g_i, input logic [W-1:0] p_i,
                                           input int lo, input int hi);
        logic [W-1:0] g, p;
        g = g_i;
        p = p_i;
        for (int l = lo + 1; l <= hi; l++) begin
            g = g | (p & (g << (1 << (l - 1))));
            p = p & (p << (1 << (l - 1)));
        end
        return g;
    endfunction

    function automatic logic [W-1:0] pfx_p(input logic [W-1:0] p_i, input int lo, input int hi);
        logic [W-1:0] p;
        p = p_i;
        for (int l = lo + 1; l <= hi; l++)
            p = p & (p << (1 << (l - 1)));
        return p;
    endfunction

    logic [PIPE:0]   sv, vi, ld;
    logic [W-1:0]    sx [PIPE+1];
    logic [W-1:0]    sg [PIPE+1];
    logic [W-1:0]    sp [PIPE+1];
    logic            sc [PIPE+1];
    logic [TAGW-1:0] st [PIPE+1];
    logic [W-1:0]    bb;

    always_comb begin
        logic r;
        r = out_ready;
        for (int k = PIPE; k >= 0; k--) begin
            r = ~sv[k] | r;
            ld[k] = r;
            vi[k] = (k == 0) ? in_valid : sv[(k > 0) ? k - 1 : 0];
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = sv[PIPE];

    always_ff @(posedge clk)
        for (int k = 0; k <= PIPE; k++)
            if (reset) sv[k] <= 1'b0;
            else if (ld[k]) sv[k] <= vi[k];

    // carry-in folded into bit 0's generate so N levels cover the whole word
    assign bb    = sub ? ~b : b;
    assign sc[0] = sub | cin;
    assign sx[0] = a ^ bb;
    assign sp[0] = a | bb;
    assign sg[0] = (a & bb) | {{(W-1){1'b0}}, (a[0] | bb[0]) & sc[0]};
    assign st[0] = tag;

    for (genvar j = 0; j <= PIPE; j++) begin : stg
        localparam int LO = cut(j);
        localparam int HI = cut(j + 1);
        if (j < PIPE) begin : mid
            logic [W-1:0]    rx, rg, rp;
            logic            rc;
            logic [TAGW-1:0] rt;
            always_ff @(posedge clk)
                if (ld[j] && vi[j]) begin
                    rx <= sx[j];
                    rg <= pfx_g(sg[j], sp[j], LO, HI);
                    rp <= pfx_p(sp[j], LO, HI);
                    rc <= sc[j];
                    rt <= st[j];
                end
            assign sx[j+1] = rx;
            assign sg[j+1] = rg;
            assign sp[j+1] = rp;
            assign sc[j+1] = rc;
            assign st[j+1] = rt;
        end else begin : fin
            logic [W-1:0] gf, cy, sn;
            assign gf = pfx_g(sg[j], sp[j], LO, HI);
            assign cy = {gf[W-2:0], sc[j]};
            assign sn = sx[j] ^ cy;
            always_ff @(posedge clk)
                if (reset) begin
                    s       <= '0;
                    cout    <= 1'b0;
                    ovf     <= 1'b0;
                    zero    <= 1'b0;
                    tag_out <= '0;
                end else if (ld[j] && vi[j]) begin
                    s       <= sn;
                    cout    <= gf[W-1];
                    ovf     <= cy[W-1] ^ gf[W-1];
                    zero    <= ~|sn;
                    tag_out <= st[j];
                end
        end
    end
endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// tb_prefix_addsub_pipe: four pipeline depths driven in parallel with random traffic,
// each checked against an arithmetic model and a queue scoreboard.
module tb_prefix_addsub_pipe;
    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        of;
        logic        z;
        logic [3:0]  t;
    } res_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int pc, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pipe=%0d got=%0h expected=%0h", nm, pc, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                   input logic sub, input logic [3:0] tag);
        res_t r;
        longint unsigned ua, ub, ur;
        longint sa, sb, sr;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            ur   = ua - ub;
            r.co = ua >= ub;
            sr   = sa - sb;
        end else begin
            ur   = ua + ub + cin;
            r.co = ur[32];
            sr   = sa + sb + cin;
        end
        r.s  = ur[31:0];
        r.of = sr > 64'sd2147483647 || sr < -64'sd2147483648;
        r.z  = r.s == 0;
        r.t  = tag;
        return r;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : cfg
        localparam int P = (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 2 : 5;
        logic        rst, iv, ir, cin_, sb, ov, ordy, co, of, z;
        logic [31:0] a_, b_, s_;
        logic [3:0]  t, to;
        res_t        q[$];
        int          nout = 0;

        prefix_addsub_pipe #(.N(5), .PIPE(P), .TAGW(4)) dut (
            .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .a(a_), .b(b_),
            .cin(cin_), .sub(sb), .tag(t), .out_valid(ov), .out_ready(ordy),
            .s(s_), .cout(co), .ovf(of), .zero(z), .tag_out(to)
        );

        res_t hs, e;
        bit   held = 0;
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                held = 0;
            end else begin
                if (held) begin
                    chk("hold_valid", P, 64'(ov), 64'(1));
                    chk("hold_data", P, 64'({s_, co, of, z, to}), 64'(hs));
                end
                if (ov && ordy) begin
                    nout++;
                    if (q.size() == 0) chk("spurious_out", P, 64'(1), 64'(0));
                    else begin
                        e = q.pop_front();
                        chk("s", P, 64'(s_), 64'(e.s));
                        chk("cout", P, 64'(co), 64'(e.co));
                        chk("ovf", P, 64'(of), 64'(e.of));
                        chk("zero", P, 64'(z), 64'(e.z));
                        chk("tag", P, 64'(to), 64'(e.t));
                    end
                end
                if (iv && ir) q.push_back(model(a_, b_, cin_, sb, t));
                held = ov && !ordy;
                hs   = {s_, co, of, z, to};
            end
        end

        task automatic rand_in();
            a_   = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            b_   = ($urandom % 8 == 0) ? a_ : $urandom;
            cin_ = 1'($urandom % 2);
            sb   = 1'($urandom % 2);
        endtask

        task automatic step();
            @(posedge clk);
            #2;
        endtask

        task automatic drain();
            int n = 0;
            while (q.size() != 0 && n < 300) begin
                step();
                n++;
            end
            chk("drain", P, 64'(q.size()), 64'(0));
        endtask

        task automatic dir(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vs,
                           input logic [31:0] es, input logic eco, input logic eof, input logic ez);
            int n = 0;
            a_ = va; b_ = vb; cin_ = vc; sb = vs; t = 4'hA; iv = 1; ordy = 1;
            step();
            iv = 0;
            while (!ov && n < 20) begin
                step();
                n++;
            end
            chk("latency", P, 64'(n), 64'(P));
            chk("dir_s", P, 64'(s_), 64'(es));
            chk("dir_cout", P, 64'(co), 64'(eco));
            chk("dir_ovf", P, 64'(of), 64'(eof));
            chk("dir_zero", P, 64'(z), 64'(ez));
            chk("dir_tag", P, 64'(to), 64'(4'hA));
        endtask

        initial begin
            int acc, sent, cyc, n0;
            logic r0;
            rst = 1; iv = 0; ordy = 0; a_ = 0; b_ = 0; cin_ = 0; sb = 0; t = 0;
            repeat (3) @(posedge clk);
            #2 rst = 0;
            chk("rst_in_ready", P, 64'(ir), 64'(1));
            chk("rst_out_valid", P, 64'(ov), 64'(0));
            chk("rst_outputs", P, 64'({s_, co, of, z, to}), 64'(0));

            dir(32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0, 1, 0, 1);
            dir(32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0);
            dir(32'h5, 32'h7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0);
            dir(32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1, 0);
            drain();

            // back-to-back: one result per cycle once the pipe fills
            ordy = 1;
            n0 = nout;
            for (int i = 0; i < 64; i++) begin
                rand_in();
                t = 4'(i % 16);
                iv = 1;
                chk("b2b_ready", P, 64'(ir), 64'(1));
                step();
                if (i >= P) chk("b2b_valid", P, 64'(ov), 64'(1));
            end
            iv = 0;
            drain();
            chk("b2b_count", P, 64'(nout - n0), 64'(64));

            // fill with the consumer stalled
            ordy = 0;
            iv = 1;
            acc = 0;
            repeat (P + 4) begin
                rand_in();
                t = 4'($urandom);
                if (ir) acc++;
                step();
            end
            chk("full_accepted", P, 64'(acc), 64'(P + 1));
            chk("full_ready", P, 64'(ir), 64'(0));
            ordy = 1;
            #1;
            chk("ready_same_cycle", P, 64'(ir), 64'(1));
            step();
            iv = 0;
            drain();

            // random valid/ready toggling
            sent = 0;
            cyc = 0;
            while (sent < 1000 && cyc < 20000) begin
                rand_in();
                t = 4'($urandom);
                ordy = 1'($urandom % 2);
                iv = 0;
                #1 r0 = ir;
                iv = 1;
                #1 chk("ready_indep_valid", P, 64'(ir), 64'(r0));
                iv = 1'($urandom % 2);
                if (iv && ir) sent++;
                step();
                cyc++;
            end
            chk("random_sent", P, 64'(sent), 64'(1000));
            iv = 0;
            ordy = 1;
            drain();

            // reset with ops in flight
            ordy = 0;
            repeat (2) begin
                rand_in();
                t = 4'($urandom);
                iv = 1;
                step();
            end
            iv = 0;
            rst = 1;
            step();
            rst = 0;
            chk("midrst_out_valid", P, 64'(ov), 64'(0));
            chk("midrst_outputs", P, 64'({s_, co, of, z, to}), 64'(0));
            chk("midrst_ready", P, 64'(ir), 64'(1));
            ordy = 1;
            n0 = nout;
            repeat (10) step();
            chk("no_stale", P, 64'(nout - n0), 64'(0));
            for (int i = 0; i < 8; i++) begin
                rand_in();
                t = 4'(i);
                iv = 1;
                step();
            end
            iv = 0;
            drain();
            chk("post_rst_count", P, 64'(nout - n0), 64'(8));
            done++;
        end
    end

    initial begin
        int cyc = 0;
        while (done < 4 && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        if (done < 4) begin
            errors++;
            $display("FAIL timeout finished=%0d required=4", done);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
